key_bar_led: RTL

KEY_BAR_LED -- requirements
Module: key_bar_led

---
 rtl/key_bar_led.sv | 125 ++++++++++++
 1 files changed

// File: rtl/key_bar_led.sv
// Debounced active-low key bank driving an active-low LED bar (MODE=0) or toggle LEDs (MODE=1).
// Latency: a key level change is accepted DEBOUNCE_CYCLES+3 edges after it is first sampled.
// No backpressure: press_valid is a one-cycle pulse; the lowest-index press wins a tie.
module key_bar_led #(
  parameter int NUM_KEYS        = 6,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int MODE            = 0,
  localparam int IDX_W          = $clog2(NUM_KEYS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] led,
  output logic                press_valid,
  output logic [IDX_W-1:0]    press_idx
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] key_s;
  logic [NUM_KEYS-1:0] key_db;
  logic [NUM_KEYS-1:0] key_db_d;
  logic [CNT_W-1:0]    cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] fall;
  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic [IDX_W-1:0]    level;
  logic [IDX_W-1:0]    level_nxt;
  logic [NUM_KEYS-1:0] led_nxt;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      key_s <= '1;
    end else begin
      sync1 <= key;
      key_s <= sync1;
    end
  end

  // Per-key debounce: count consecutive mismatching samples, accept on the DEBOUNCE_CYCLES-th.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_db <= '1;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_s[i] == key_db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]    <= '0;
          key_db[i] <= key_s[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Delayed debounced state, used to spot 1->0 (press) transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_db_d <= '1;
    end else begin
      key_db_d <= key_db;
    end
  end

  assign fall = key_db_d & ~key_db;

  // Priority pick: scanning downward lets the lowest pressed index overwrite the others.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (fall[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i + 1);
      end
    end
  end

  // Next LED pattern: bar level update (pressing the current level clears it) or single-bit toggle.
  always_comb begin
    level_nxt = level;
    led_nxt   = led;
    if (hit) begin
      if (MODE == 0) begin
        level_nxt = (hit_idx == level) ? '0 : hit_idx;
        for (int i = 0; i < NUM_KEYS; i++) begin
          led_nxt[i] = !(IDX_W'(i) < level_nxt);
        end
      end else begin
        for (int i = 0; i < NUM_KEYS; i++) begin
          if (hit_idx == IDX_W'(i + 1)) begin
            led_nxt[i] = ~led[i];
          end
        end
      end
    end
  end

  // Output registers; press_idx keeps the last accepted key between events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level       <= '0;
      led         <= '1;
      press_valid <= 1'b0;
      press_idx   <= '0;
    end else begin
      level       <= level_nxt;
      led         <= led_nxt;
      press_valid <= hit;
      if (hit) begin
        press_idx <= hit_idx;
      end
    end
  end

endmodule
